// File: rtl/acc5_accumulator.sv
// Sequential accumulator fed by the 5-bit ripple-carry adder: adds accepted operands
// into a running total, tracks carry/overflow, and stalls once the accept count saturates.
module acc5_accumulator #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    output logic [WIDTH-1:0] acc,
    output logic             acc_cout,
    output logic             overflow,
    output logic [CNT_W-1:0] count,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             SAT_MODE = (SATURATE != 0);

    state_t           state;
    logic [WIDTH:0]   sum;
    logic             accept;

    // Same function as the full-adder chain, with the carry landing in sum[WIDTH].
    assign sum      = {1'b0, acc} + {1'b0, in_data} + {{WIDTH{1'b0}}, in_cin};
    assign in_ready = (state != FULL);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            acc_cout  <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            // Clear wins over a simultaneous accept; that operand is dropped.
            state     <= IDLE;
            acc       <= '0;
            acc_cout  <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                acc_cout <= sum[WIDTH];
                overflow <= overflow | sum[WIDTH];
                acc      <= (SAT_MODE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
                count    <= count + 1'b1;
                state    <= (count == CNT_MAX - 1'b1) ? FULL : RUN;
            end
        end
    end

endmodule

// File: tb/tb_acc5_accumulator.sv
// Directed bench for acc5_accumulator: a wrapping and a saturating instance share stimulus.
module tb_acc5_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [4:0] in_data;
    logic       in_cin;

    logic       w_ready, s_ready;
    logic [4:0] w_acc, s_acc;
    logic       w_cout, s_cout;
    logic       w_ovf, s_ovf;
    logic [3:0] w_cnt, s_cnt;
    logic       w_ov, s_ov;

    int checks = 0;
    int errors = 0;
    int pulses;

    acc5_accumulator #(.WIDTH(5), .SATURATE(0), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_ready),
        .in_data(in_data), .in_cin(in_cin), .acc(w_acc), .acc_cout(w_cout),
        .overflow(w_ovf), .count(w_cnt), .out_valid(w_ov)
    );

    acc5_accumulator #(.WIDTH(5), .SATURATE(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_ready),
        .in_data(in_data), .in_cin(in_cin), .acc(s_acc), .acc_cout(s_cout),
        .overflow(s_ovf), .count(s_cnt), .out_valid(s_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Present one operand for a single edge, then return #1 after that edge.
    task automatic op(input logic [4:0] d, input logic c);
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_cin   = 1'b0;
        #12;
        check("rst_acc", w_acc, 0);
        check("rst_cnt", w_cnt, 0);
        check("rst_ovf", w_ovf, 0);
        check("rst_cout", w_cout, 0);
        check("rst_ov", w_ov, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", w_ready, 1);

        // Test 1: 15 then 1
        op(5'd15, 1'b0);
        check("t1_acc15", w_acc, 15);
        check("t1_ov1", w_ov, 1);
        check("t1_cnt1", w_cnt, 1);
        op(5'd1, 1'b0);
        check("t1_acc16", w_acc, 16);
        check("t1_cout", w_cout, 0);
        check("t1_ovf", w_ovf, 0);
        check("t1_cnt2", w_cnt, 2);
        check("t1_ov2", w_ov, 1);
        @(posedge clk);
        #1;
        check("t1_ov_drop", w_ov, 0);
        check("t1_hold", w_acc, 16);

        // Test 2: wrap from 31
        do_clr();
        op(5'd31, 1'b0);
        check("t2_acc31", w_acc, 31);
        op(5'd1, 1'b0);
        check("t2_wrap", w_acc, 0);
        check("t2_cout1", w_cout, 1);
        check("t2_ovf1", w_ovf, 1);
        check("t2_sat_clamp", s_acc, 31);
        op(5'd2, 1'b0);
        check("t2_acc2", w_acc, 2);
        check("t2_cout0", w_cout, 0);
        check("t2_ovf_sticky", w_ovf, 1);

        // Test 3: saturating instance
        do_clr();
        check("t3_clr_ovf", s_ovf, 0);
        op(5'd30, 1'b0);
        check("t3_acc30", s_acc, 30);
        op(5'd3, 1'b0);
        check("t3_acc31", s_acc, 31);
        check("t3_cout", s_cout, 1);
        check("t3_ovf", s_ovf, 1);
        check("t3_wrap_acc1", w_acc, 1);
        op(5'd0, 1'b1);
        check("t3_inc_sat", s_acc, 31);
        check("t3_inc_cout", s_cout, 1);
        check("t3_inc_ovf", s_ovf, 1);
        check("t3_inc_wrap", w_acc, 2);
        check("t3_inc_wcout", w_cout, 0);

        // Test 4: hold in_valid for 20 cycles
        do_clr();
        pulses   = 0;
        in_valid = 1'b1;
        in_data  = 5'd1;
        in_cin   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (w_ov) pulses++;
            if (i == 13) check("t4_ready_at14", w_ready, 1);
            if (i == 14) check("t4_ready_at15", w_ready, 0);
        end
        check("t4_pulses", pulses, 15);
        check("t4_cnt", w_cnt, 15);
        check("t4_acc", w_acc, 15);
        check("t4_ov", w_ov, 0);
        check("t4_ready", w_ready, 0);
        check("t4_sat_cnt", s_cnt, 15);

        // Test 5: clr with in_valid from FULL
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t5_acc", w_acc, 0);
        check("t5_cnt", w_cnt, 0);
        check("t5_ovf", w_ovf, 0);
        check("t5_ov", w_ov, 0);
        check("t5_ready", w_ready, 1);

        // Test 6: async reset mid-stream
        op(5'd4, 1'b0);
        op(5'd3, 1'b0);
        op(5'd2, 1'b0);
        check("t6_acc9", w_acc, 9);
        check("t6_cnt3", w_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_acc", w_acc, 0);
        check("t6_async_cnt", w_cnt, 0);
        check("t6_async_ov", w_ov, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op(5'd4, 1'b0);
        check("t6_acc4", w_acc, 4);
        check("t6_cnt1", w_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
